// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide beside the ALU: shift-add multiply, restoring divide.
// Latency: done pulses 34 cycles after the start cycle, or 2 cycles for early-out divide corner cases.
// Backpressure: busy_o stays high while an op is in flight; start_i is ignored until IDLE.
`timescale 1ns/1ps
module cpu_muldiv #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;        // |src_a|
  logic [31:0] b_q, b_d;        // |src_b|
  logic [63:0] acc_q, acc_d;    // mul: {hi, lo} product; div: {remainder, quotient}
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Operand decode at issue time
  logic        sgn_a_in, sgn_b_in, sa_in, sb_in, div0_in, ovf_in;
  logic [31:0] a_mag_in, b_mag_in;

  // One iteration of each algorithm
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;

  // Sign fix-up and result selection
  logic [63:0] prod_s;
  logic [31:0] q_s, r_s, a_s, fin_res;

  // Operand signedness, magnitudes and divide corner cases for the op being issued
  always_comb begin
    sgn_a_in = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    sgn_b_in = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    sa_in    = sgn_a_in & src_a_i[31];
    sb_in    = sgn_b_in & src_b_i[31];
    a_mag_in = sa_in ? (32'd0 - src_a_i) : src_a_i;
    b_mag_in = sb_in ? (32'd0 - src_b_i) : src_b_i;
    div0_in  = op_i[2] && (src_b_i == 32'd0);
    ovf_in   = op_i[2] && !op_i[0] && (src_a_i == 32'h8000_0000) && (src_b_i == 32'hFFFF_FFFF);
  end

  // Shift-add multiply step and restoring divide step on the shared accumulator
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_ge   = (div_sh >= {1'b0, b_q});
    // When div_ge holds the true difference is below the divisor, so 32 bits suffice
    div_sub  = div_sh[31:0] - b_q;
    div_next = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                      : {div_sh[31:0], acc_q[30:0], 1'b0};
  end

  // Apply result signs and pick the architectural result; corner cases override
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
    q_s    = (sa_q ^ sb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    r_s    = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    a_s    = sa_q ? (32'd0 - a_q) : a_q;
    case (op_q)
      3'b000:                 fin_res = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[63:32];
      3'b100, 3'b101:         fin_res = div0_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : q_s);
      default:                fin_res = div0_q ? a_s : (ovf_q ? 32'd0 : r_s);
    endcase
  end

  // Next-state and datapath updates; flush overrides everything
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_d   = op_i;
            a_d    = a_mag_in;
            b_d    = b_mag_in;
            sa_d   = sa_in;
            sb_d   = sb_in;
            div0_d = div0_in;
            ovf_d  = ovf_in;
            acc_d  = {32'd0, (op_i[2] ? a_mag_in : b_mag_in)};
            cnt_d  = 6'd0;
            state_d = (EARLY_OUT && (div0_in || ovf_in)) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_FIN;
        end
        S_FIN: begin
          result_d = fin_res;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= 6'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
